// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word requests, tracks in-flight
// addresses, buffers returned instructions for decode and squashes stale responses on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_pc
);

  localparam int AW  = $clog2(QDEPTH);
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] QDEPTH_C = CW1'(QDEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] q_count_q, q_count_d;
  logic [CW-1:0] drop_count_q, drop_count_d;
  logic [AW-1:0] af_rd_q, af_rd_d, af_wr_q, af_wr_d;
  logic [AW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
  logic [31:0]   af_mem_q [QDEPTH];
  logic [31:0]   af_mem_d [QDEPTH];
  logic [31:0]   qd_mem_q [QDEPTH];
  logic [31:0]   qd_mem_d [QDEPTH];
  logic [31:0]   qp_mem_q [QDEPTH];
  logic [31:0]   qp_mem_d [QDEPTH];

  logic [CW:0] inflight_s;
  logic        req_valid_s, req_fire_s, rsp_take_s, push_s, pop_s;

  // Next-state computation for the FSM, counters, address FIFO and instruction queue
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    q_count_d     = q_count_q;
    drop_count_d  = drop_count_q;
    af_rd_d       = af_rd_q;
    af_wr_d       = af_wr_q;
    q_rd_d        = q_rd_q;
    q_wr_d        = q_wr_q;
    af_mem_d      = af_mem_q;
    qd_mem_d      = qd_mem_q;
    qp_mem_d      = qp_mem_q;

    // Credits cover both in-flight requests and buffered entries, so the queue cannot overflow.
    inflight_s  = {1'b0, outstanding_q} + {1'b0, q_count_q};
    req_valid_s = (state_q == FETCH) && !redirect_valid && (inflight_s < QDEPTH_C);
    req_fire_s  = req_valid_s && imem_req_ready;
    rsp_take_s  = imem_rsp_valid && (outstanding_q != '0);
    push_s      = rsp_take_s && !redirect_valid && (drop_count_q == '0);
    pop_s       = (q_count_q != '0) && inst_ready && !redirect_valid;

    if (req_fire_s) begin
      af_mem_d[af_wr_q] = fetch_pc_q;
      af_wr_d           = af_wr_q + AW'(1);
      fetch_pc_d        = fetch_pc_q + 32'd4;
    end else begin
      af_wr_d = af_wr_q;
    end

    if (rsp_take_s) begin
      af_rd_d = af_rd_q + AW'(1);
    end else begin
      af_rd_d = af_rd_q;
    end

    case ({req_fire_s, rsp_take_s})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect_valid) begin
      // Address FIFO is left intact so stale responses still pop in order.
      fetch_pc_d   = {redirect_pc[31:2], 2'b00};
      q_wr_d       = q_rd_q;
      q_count_d    = '0;
      drop_count_d = rsp_take_s ? (outstanding_q - CW'(1)) : outstanding_q;
    end else begin
      if (rsp_take_s && (drop_count_q != '0)) begin
        drop_count_d = drop_count_q - CW'(1);
      end else begin
        drop_count_d = drop_count_q;
      end
      if (push_s) begin
        qd_mem_d[q_wr_q] = imem_rsp_data;
        qp_mem_d[q_wr_q] = af_mem_q[af_rd_q];
        q_wr_d           = q_wr_q + AW'(1);
      end else begin
        q_wr_d = q_wr_q;
      end
      if (pop_s) begin
        q_rd_d = q_rd_q + AW'(1);
      end else begin
        q_rd_d = q_rd_q;
      end
      case ({push_s, pop_s})
        2'b10:   q_count_d = q_count_q + CW'(1);
        2'b01:   q_count_d = q_count_q - CW'(1);
        default: q_count_d = q_count_q;
      endcase
    end

    case (state_q)
      IDLE:         state_d = FETCH;
      FETCH, DRAIN: state_d = (drop_count_d != '0) ? DRAIN : FETCH;
      default:      state_d = IDLE;
    endcase
  end

  // State and storage registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      q_count_q     <= '0;
      drop_count_q  <= '0;
      af_rd_q       <= '0;
      af_wr_q       <= '0;
      q_rd_q        <= '0;
      q_wr_q        <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        af_mem_q[i] <= 32'h0;
        qd_mem_q[i] <= 32'h0;
        qp_mem_q[i] <= 32'h0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      q_count_q     <= q_count_d;
      drop_count_q  <= drop_count_d;
      af_rd_q       <= af_rd_d;
      af_wr_q       <= af_wr_d;
      q_rd_q        <= q_rd_d;
      q_wr_q        <= q_wr_d;
      af_mem_q      <= af_mem_d;
      qd_mem_q      <= qd_mem_d;
      qp_mem_q      <= qp_mem_d;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;
  assign fetch_pc       = fetch_pc_q;
  assign inst_valid     = (q_count_q != '0);
  assign inst_data      = qd_mem_q[q_rd_q];
  assign inst_pc        = qp_mem_q[q_rd_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected requests and
// instructions; a negedge monitor pops and compares on every handshake.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] fetch_pc;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int mem_lat = 1;
  int flush_req = 0;
  int junk_req  = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_ipc[$];
  logic [31:0] exp_idata[$];

  fetch_unit dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .fetch_pc(fetch_pc)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_inst(input logic [31:0] pc);
    exp_ipc.push_back(pc);
    exp_idata.push_back(~pc);
  endtask

  // Hold ready until n request handshakes are seen; returns at posedge+1 after the last one.
  task automatic allow_reqs(input int n);
    int got = 0;
    int t   = 0;
    imem_req_ready = 1'b1;
    while (got < n) begin
      #1;
      if (imem_req_valid) got++;
      tick();
      t++;
      if (t > 20) begin
        n_total++;
        $display("FAIL allow_reqs: timed out after %0d of %0d requests", got, n);
        break;
      end
    end
    imem_req_ready = 1'b0;
  endtask

  task automatic restart();
    reset          = 1'b0;
    flush_req++;
    exp_req.delete();
    exp_ipc.delete();
    exp_idata.delete();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check_sb_empty(input string tag);
    check({tag, "_req_left"}, 32'(exp_req.size()), 32'd0);
    check({tag, "_inst_left"}, 32'(exp_ipc.size()), 32'd0);
  endtask

  // Memory model: fixed-latency in-order responder, data = ~address
  initial begin : mem_model
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          seen_flush;
    int          seen_junk;
    seen_flush     = 0;
    seen_junk      = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clock);
      if (flush_req != seen_flush) begin
        mq_addr.delete();
        mq_due.delete();
        seen_flush = flush_req;
      end
      if (reset && imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + mem_lat);
      end
      @(posedge clock);
      #1;
      if (junk_req != seen_junk) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        seen_junk++;
      end else if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~mq_addr.pop_front();
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Monitor: compares every request and decode handshake against the scoreboard
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (reset) begin
        if (imem_req_valid && imem_req_ready) begin
          if (exp_req.size() == 0) begin
            n_total++;
            $display("FAIL req_unexpected: got %h expected no request", imem_req_addr);
          end else begin
            check("req_addr", imem_req_addr, exp_req.pop_front());
          end
        end
        if (inst_valid && inst_ready) begin
          if (exp_ipc.size() == 0) begin
            n_total++;
            $display("FAIL inst_unexpected: got pc %h expected no instruction", inst_pc);
          end else begin
            check("inst_pc", inst_pc, exp_ipc.pop_front());
            check("inst_data", inst_data, exp_idata.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    wait_cycles(2);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_fetch_pc", fetch_pc, 32'h0);

    // Streaming with 1-cycle memory
    restart();
    check("idle_no_req", 32'(imem_req_valid), 32'd0);
    mem_lat    = 1;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(32'(i * 4));
      expect_inst(32'(i * 4));
    end
    allow_reqs(4);
    wait_cycles(5);
    check_sb_empty("stream");
    check("stream_fetch_pc", fetch_pc, 32'h10);

    // Backpressure: credits stop issue at QDEPTH
    restart();
    mem_lat        = 1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_req.push_back(32'(i * 4));
    wait_cycles(10);
    check("bp_req_blocked", 32'(imem_req_valid), 32'd0);
    check("bp_inst_valid", 32'(inst_valid), 32'd1);
    check("bp_head_pc", inst_pc, 32'h0);
    check("bp_head_data", inst_data, 32'hFFFF_FFFF);
    check("bp_fetch_pc", fetch_pc, 32'h10);
    expect_inst(32'h0);
    exp_req.push_back(32'h10);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    wait_cycles(5);
    check("bp2_req_blocked", 32'(imem_req_valid), 32'd0);
    check("bp2_fetch_pc", fetch_pc, 32'h14);
    check("bp2_head_pc", inst_pc, 32'h4);
    imem_req_ready = 1'b0;
    for (int i = 1; i < 5; i++) expect_inst(32'(i * 4));
    inst_ready = 1'b1;
    wait_cycles(6);
    check_sb_empty("bp");
    check("bp_drained", 32'(inst_valid), 32'd0);

    // Redirect with two stale responses in flight on a 3-cycle memory
    restart();
    mem_lat    = 3;
    inst_ready = 1'b1;
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    allow_reqs(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    check("redir_blocks_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("drain_no_req_a", 32'(imem_req_valid), 32'd0);
    check("drain_inst_valid", 32'(inst_valid), 32'd0);
    check("drain_fetch_pc", fetch_pc, 32'h100);
    check("drain_req_addr", imem_req_addr, 32'h100);
    tick();
    check("drain_no_req_b", 32'(imem_req_valid), 32'd0);
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    expect_inst(32'h100);
    expect_inst(32'h104);
    allow_reqs(2);
    wait_cycles(8);
    check_sb_empty("drain");

    // Redirect in the same cycle as the only outstanding response
    restart();
    mem_lat    = 3;
    inst_ready = 1'b1;
    exp_req.push_back(32'h0);
    allow_reqs(1);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("same_cyc_req_valid", 32'(imem_req_valid), 32'd1);
    check("same_cyc_req_addr", imem_req_addr, 32'h200);
    check("same_cyc_inst_valid", 32'(inst_valid), 32'd0);
    exp_req.push_back(32'h200);
    expect_inst(32'h200);
    allow_reqs(1);
    wait_cycles(6);
    check_sb_empty("same_cyc");
    check("same_cyc_fetch_pc", fetch_pc, 32'h204);

    // Address wrap-around
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    exp_req.push_back(32'hFFFF_FFF8);
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);
    expect_inst(32'hFFFF_FFF8);
    expect_inst(32'hFFFF_FFFC);
    expect_inst(32'h0);
    allow_reqs(3);
    wait_cycles(5);
    check_sb_empty("wrap");
    check("wrap_fetch_pc", fetch_pc, 32'h4);

    // Asynchronous reset with outstanding=3, q_count=1; late responses must be ignored
    restart();
    mem_lat = 4;
    for (int i = 0; i < 4; i++) exp_req.push_back(32'(i * 4));
    allow_reqs(4);
    tick();
    check("pre_rst_inst_valid", 32'(inst_valid), 32'd1);
    check("pre_rst_inst_pc", inst_pc, 32'h0);
    #3;
    reset = 1'b0;
    #1;
    check("arst_req_valid", 32'(imem_req_valid), 32'd0);
    check("arst_inst_valid", 32'(inst_valid), 32'd0);
    check("arst_inst_data", inst_data, 32'h0);
    check("arst_inst_pc", inst_pc, 32'h0);
    check("arst_req_addr", imem_req_addr, 32'h0);
    check("arst_fetch_pc", fetch_pc, 32'h0);
    tick();
    tick();
    reset   = 1'b1;
    mem_lat = 1;
    junk_req++;
    inst_ready = 1'b1;
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    expect_inst(32'h0);
    expect_inst(32'h4);
    allow_reqs(2);
    wait_cycles(6);
    check_sb_empty("post_rst");
    check("post_rst_fetch_pc", fetch_pc, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
